// File: rtl/reset_sequencer.sv
// reset_sequencer: filters PLL lock flags, releases staged resets in order and performs glitch-safe TX clock-mux switching
// Ports:
//   i_sys_clk      system clock
//   i_sys_rst      synchronous active-high reset
//   i_pll_locked   asynchronous PLL lock flags, one per PLL
//   i_clk_sel_req  requested TX clock select (0=44k1, 1=48k), quasi-static
//   i_clear_sticky one-cycle pulse clearing o_lock_lost
//   o_clk_sel      registered select to the TX clock BUFGMUX
//   o_rst          sequenced active-high resets; the top bit is the TX domain
//   o_all_locked   filtered all-locked indication
//   o_lock_lost    sticky flag: a lock dropped after the first release began
//   o_busy         high whenever the sequencer is not in steady-state run
module reset_sequencer #(
   parameter int NUM_LOCKS   = 3,
   parameter int NUM_STAGES  = 2,
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_FILTER = 16,
   parameter int STAGE_DELAY = 25,
   parameter int SWITCH_HOLD = 8,
   parameter int CNT_W       = 8
) (
   input  logic                  i_sys_clk,
   input  logic                  i_sys_rst,
   input  logic [NUM_LOCKS-1:0]  i_pll_locked,
   input  logic                  i_clk_sel_req,
   input  logic                  i_clear_sticky,
   output logic                  o_clk_sel,
   output logic [NUM_STAGES-1:0] o_rst,
   output logic                  o_all_locked,
   output logic                  o_lock_lost,
   output logic                  o_busy
);
   typedef enum logic [2:0] {WAIT_LOCK, RELEASE, RUN, SWITCH_PRE, SWITCH_POST} state_t;
   state_t state_q, state_d;
   logic [SYNC_STAGES-1:0][NUM_LOCKS-1:0] sync_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [NUM_STAGES-1:0] rst_q, rst_d;
   logic sel_q, sel_d, req_q, req_d, all_q, all_d, lost_q, lost_d, busy_q, busy_d, lk_all;
   assign lk_all = &sync_q[SYNC_STAGES-1];
   assign o_clk_sel = sel_q;
   assign o_rst = rst_q;
   assign o_all_locked = all_q;
   assign o_lock_lost = lost_q;
   assign o_busy = busy_q;
   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         sync_q  <= '0;
         state_q <= WAIT_LOCK;
         cnt_q   <= '0;
         rst_q   <= '1;
         sel_q   <= 1'b0;
         req_q   <= 1'b0;
         all_q   <= 1'b0;
         lost_q  <= 1'b0;
         busy_q  <= 1'b1;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], i_pll_locked};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rst_q   <= rst_d;
         sel_q   <= sel_d;
         req_q   <= req_d;
         all_q   <= all_d;
         lost_q  <= lost_d;
         busy_q  <= busy_d;
      end
   end
   // One counter serves the lock filter, the stage delay and both switch holds.
   // Stages are released by shifting zeros in from bit 0, so bit 0 always falls first.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rst_d   = rst_q;
      sel_d   = sel_q;
      req_d   = req_q;
      all_d   = all_q;
      lost_d  = i_clear_sticky ? 1'b0 : lost_q;
      case (state_q)
         WAIT_LOCK: begin
            if (cnt_q == CNT_W'(LOCK_FILTER)) begin
               state_d = RELEASE;
               all_d   = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = lk_all ? cnt_q + CNT_W'(1) : '0;
            end
         end
         RELEASE: begin
            if (cnt_q == CNT_W'(STAGE_DELAY - 1)) begin
               rst_d   = rst_q << 1;
               cnt_d   = '0;
               state_d = ((rst_q << 1) == '0) ? RUN : RELEASE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RUN: begin
            if (sel_q != i_clk_sel_req) begin
               req_d = i_clk_sel_req;
               rst_d[NUM_STAGES-1] = 1'b1;
               cnt_d   = '0;
               state_d = SWITCH_PRE;
            end
         end
         SWITCH_PRE: begin
            if (cnt_q == CNT_W'(SWITCH_HOLD - 1)) begin
               sel_d   = req_q;
               cnt_d   = '0;
               state_d = SWITCH_POST;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SWITCH_POST: begin
            if (cnt_q == CNT_W'(SWITCH_HOLD - 1)) begin
               rst_d[NUM_STAGES-1] = 1'b0;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = WAIT_LOCK;
      endcase
      // Lock loss overrides any stage or switch event decided above; the mux select is left alone.
      if (state_q != WAIT_LOCK && !lk_all) begin
         state_d = WAIT_LOCK;
         cnt_d   = '0;
         rst_d   = '1;
         all_d   = 1'b0;
         lost_d  = 1'b1;
      end
      busy_d = (state_d != RUN);
   end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed and randomized checks of reset_sequencer against a timeline reference model
module tb_reset_sequencer;
   localparam int NL = 3, NS = 2, SS = 2, LF = 16, SD = 25, SH = 8;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NL-1:0] locks = '0;
   logic req = 1'b0, clr = 1'b0;
   logic sel, all_l, lost, busy;
   logic [NS-1:0] rsto;
   logic [NS+3:0] obs;
   int checks = 0, errors = 0;
   // reference model: event times in absolute edge numbers
   int cyc = 0, ss = -1, t_rel = 0, sw_start = 0;
   bit ph = 0, sw = 0, sw_req = 0, m_sel = 0, m_lost = 0;
   logic [NL-1:0] hist[$];
   always #5 clk = ~clk;
   assign obs = {rsto, sel, all_l, lost, busy};
   reset_sequencer #(
      .NUM_LOCKS(NL), .NUM_STAGES(NS), .SYNC_STAGES(SS), .LOCK_FILTER(LF),
      .STAGE_DELAY(SD), .SWITCH_HOLD(SH), .CNT_W(8)
   ) dut (
      .i_sys_clk(clk), .i_sys_rst(rst), .i_pll_locked(locks), .i_clk_sel_req(req),
      .i_clear_sticky(clr), .o_clk_sel(sel), .o_rst(rsto), .o_all_locked(all_l),
      .o_lock_lost(lost), .o_busy(busy)
   );
   task automatic model_step();
      logic [NL-1:0] lk;
      cyc++;
      if (rst) begin
         hist.delete();
         repeat (SS) hist.push_back('0);
         ph = 0; ss = -1; sw = 0; m_sel = 0; m_lost = 0;
      end else begin
         lk = hist.pop_front();
         hist.push_back(locks);
         if (ph && cyc > t_rel && !(&lk)) begin
            ph = 0; ss = -1; sw = 0; m_lost = 1;
         end else begin
            if (clr) m_lost = 0;
            if (!ph) begin
               if (ss >= 0 && cyc - ss == LF) begin ph = 1; t_rel = cyc; end
               else if (&lk) begin if (ss < 0) ss = cyc; end
               else ss = -1;
            end else begin
               if (sw && cyc == sw_start + SH) m_sel = sw_req;
               if (sw && cyc == sw_start + 2 * SH) sw = 0;
               else if (!sw && cyc > t_rel + NS * SD && m_sel != req) begin
                  sw = 1; sw_start = cyc; sw_req = req;
               end
            end
         end
      end
   endtask
   function automatic logic [NS+3:0] exp_vec();
      logic [NS-1:0] r;
      r = '1;
      if (ph) begin
         for (int s = 0; s < NS; s++) r[s] = (cyc < t_rel + (s + 1) * SD);
         if (sw) r[NS-1] = 1'b1;
      end
      return {r, m_sel, ph, m_lost, !(ph && !sw && cyc >= t_rel + NS * SD)};
   endfunction
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask
   task automatic test_reset();
      rst = 1; locks = '0; req = 0; clr = 0;
      repeat (3) tick();
      checks++; if (obs !== 6'b110001) begin errors++; $display("FAIL reset_values got %b exp %b", obs, 6'b110001); end
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL reset_model got %b exp %b", obs, exp_vec()); end
      rst = 0;
   endtask
   task automatic test_bringup();
      int n_all = -1, n_r0 = -1, n_r1 = -1;
      locks = '1;
      for (int k = 0; k < 80; k++) begin
         tick();
         checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL bringup k=%0d got %b exp %b", k, obs, exp_vec()); end
         if (all_l && n_all < 0) n_all = k;
         if (!rsto[0] && n_r0 < 0) n_r0 = k;
         if (!rsto[1] && n_r1 < 0) n_r1 = k;
      end
      checks++; if (n_all != 2 + LF) begin errors++; $display("FAIL bringup_all_locked edge %0d exp %0d", n_all, 2 + LF); end
      checks++; if (n_r0 != 2 + LF + SD) begin errors++; $display("FAIL bringup_rst0 edge %0d exp %0d", n_r0, 2 + LF + SD); end
      checks++; if (n_r1 != 2 + LF + 2 * SD) begin errors++; $display("FAIL bringup_rst1 edge %0d exp %0d", n_r1, 2 + LF + 2 * SD); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bringup_busy got %b exp 0", busy); end
   endtask
   task automatic test_glitch();
      int n_all = -1, n_r1 = -1;
      rst = 1; tick(); rst = 0;
      for (int k = 0; k < 120; k++) begin
         locks = (k == 12) ? 3'b101 : 3'b111;
         tick();
         checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL glitch k=%0d got %b exp %b", k, obs, exp_vec()); end
         if (all_l && n_all < 0) n_all = k;
         if (!rsto[1] && n_r1 < 0) n_r1 = k;
      end
      checks++; if (n_all != 13 + 2 + LF) begin errors++; $display("FAIL glitch_all_locked edge %0d exp %0d", n_all, 13 + 2 + LF); end
      checks++; if (n_r1 != 13 + 2 + LF + 2 * SD) begin errors++; $display("FAIL glitch_rst1 edge %0d exp %0d", n_r1, 13 + 2 + LF + 2 * SD); end
      checks++; if (lost !== 1'b0) begin errors++; $display("FAIL glitch_sticky got %b exp 0", lost); end
   endtask
   task automatic test_lock_loss();
      int n = -1;
      locks = 3'b011;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL loss k=%0d got %b exp %b", k, obs, exp_vec()); end
         if (rsto === 2'b11 && n < 0) n = k;
      end
      checks++; if (n != SS) begin errors++; $display("FAIL loss_latency edge %0d exp %0d", n, SS); end
      checks++; if (lost !== 1'b1) begin errors++; $display("FAIL loss_sticky got %b exp 1", lost); end
      locks = '1;
      for (int k = 0; k < 90; k++) begin
         tick();
         checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL relock k=%0d got %b exp %b", k, obs, exp_vec()); end
      end
      checks++; if (obs !== 6'b000110) begin errors++; $display("FAIL relock_final got %b exp %b", obs, 6'b000110); end
   endtask
   task automatic test_switch();
      int n_set = -1, n_sel = -1, n_clr = -1;
      req = 1;
      for (int k = 0; k < 20; k++) begin
         tick();
         checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL switch k=%0d got %b exp %b", k, obs, exp_vec()); end
         checks++; if (rsto[0] !== 1'b0) begin errors++; $display("FAIL switch_rst0 k=%0d got %b exp 0", k, rsto[0]); end
         if (rsto[1] && n_set < 0) n_set = k;
         if (sel && n_sel < 0) n_sel = k;
         if (n_set >= 0 && !rsto[1] && n_clr < 0) n_clr = k;
      end
      checks++; if (n_set != 0) begin errors++; $display("FAIL switch_rst1_set edge %0d exp 0", n_set); end
      checks++; if (n_sel != SH) begin errors++; $display("FAIL switch_sel edge %0d exp %0d", n_sel, SH); end
      checks++; if (n_clr != 2 * SH) begin errors++; $display("FAIL switch_rst1_clr edge %0d exp %0d", n_clr, 2 * SH); end
      req = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL switch_back k=%0d got %b exp %b", k, obs, exp_vec()); end
      end
      checks++; if (obs !== 6'b000110) begin errors++; $display("FAIL switch_back_final got %b exp %b", obs, 6'b000110); end
   endtask
   task automatic test_switch_loss();
      req = 1;
      for (int k = 0; k < 7; k++) begin
         if (k == 4) locks = 3'b110;
         tick();
         checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL swloss k=%0d got %b exp %b", k, obs, exp_vec()); end
      end
      checks++; if (obs !== 6'b110011) begin errors++; $display("FAIL swloss_state got %b exp %b", obs, 6'b110011); end
      locks = '1;
      for (int k = 0; k < 120; k++) begin
         tick();
         checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL swloss_relock k=%0d got %b exp %b", k, obs, exp_vec()); end
      end
      clr = 1; tick(); clr = 0;
      checks++; if (lost !== 1'b0) begin errors++; $display("FAIL clear_sticky got %b exp 0", lost); end
      locks = 3'b110; tick(); tick();
      clr = 1; tick(); clr = 0;
      checks++; if (lost !== 1'b1) begin errors++; $display("FAIL clear_vs_set got %b exp 1", lost); end
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL clear_vs_set_model got %b exp %b", obs, exp_vec()); end
      locks = '1;
   endtask
   task automatic test_sysrst_mid();
      bit hit = 0;
      for (int k = 0; k < 120 && !hit; k++) begin
         tick();
         checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL midrst k=%0d got %b exp %b", k, obs, exp_vec()); end
         hit = !rsto[0];
      end
      checks++; if (!hit || sel !== 1'b1) begin errors++; $display("FAIL midrst_setup rst0_released %b sel %b exp 1 1", hit, sel); end
      rst = 1; tick(); rst = 0;
      checks++; if (obs !== 6'b110001) begin errors++; $display("FAIL midrst_values got %b exp %b", obs, 6'b110001); end
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL midrst_model got %b exp %b", obs, exp_vec()); end
   endtask
   task automatic test_random();
      for (int k = 0; k < 3000; k++) begin
         locks = ($urandom_range(0, 149) == 0) ? NL'($urandom) : '1;
         if ($urandom_range(0, 99) == 0) req = ~req;
         clr = ($urandom_range(0, 39) == 0);
         rst = ($urandom_range(0, 1499) == 0);
         tick();
         checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL random k=%0d got %b exp %b", k, obs, exp_vec()); end
      end
      rst = 0; clr = 0;
   endtask
   initial begin
      repeat (SS) hist.push_back('0);
      test_reset();
      test_bringup();
      test_glitch();
      test_lock_loss();
      test_switch();
      test_switch_loss();
      test_sysrst_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
